polar_encoder_seq: RTL and testbench

POLAR_ENCODER_SEQ -- requirements
Module: polar_encoder_seq

---
 rtl/polar_encoder_seq.sv | 188 ++++++++++++++++++
 tb/tb_polar_encoder_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder: loads K information bits into non-frozen slots, runs log2(N)
// butterfly stages in place, then presents the codeword. Build option: POLAR_ENC_BITREV_EN.
module polar_encoder_seq #(
   parameter int             N           = 8,
   parameter int             K           = 4,
   parameter logic [N-1:0]   FROZEN_MASK = 8'b0001_0111
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   input  logic         in_bit,
   output logic         in_ready,
   output logic         cw_valid,
   input  logic         cw_ready,
   output logic [N-1:0] cw_data,
   output logic         busy
);

   localparam int LOGN = $clog2(N);
   localparam int CW   = $clog2(K + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ENCODE = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      u_q, u_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [LOGN-1:0]   stage_q, stage_d;
   logic              in_ready_q, in_ready_d;
   logic              cw_valid_q, cw_valid_d;
   logic              busy_q, busy_d;
   logic [N-1:0]      cw_data_q, cw_data_d;

   // One-hot mask of the k-th non-frozen position, counting up from index 0.
   function automatic logic [N-1:0] info_slot(input logic [CW-1:0] k);
      logic [N-1:0] m;
      int           cnt;
      m   = '0;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (!FROZEN_MASK[i]) begin
            if (cnt == int'(k)) begin
               m[i] = 1'b1;
            end else begin
               m[i] = 1'b0;
            end
            cnt++;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // One in-place butterfly stage: every index with bit s clear absorbs its partner i+2^s.
   function automatic logic [N-1:0] butterfly(input logic [N-1:0] u, input logic [LOGN-1:0] s);
      logic [N-1:0] r;
      r = u;
      for (int i = 0; i < N; i++) begin
         if (((i >> s) & 1) == 0) begin
            r[i] = u[i] ^ u[i + (1 << s)];
         end else begin
            r[i] = u[i];
         end
      end
      return r;
   endfunction

   function automatic logic [N-1:0] out_order(input logic [N-1:0] x);
`ifdef POLAR_ENC_BITREV_EN
      logic [N-1:0]    r;
      logic [LOGN-1:0] jv;
      logic [LOGN-1:0] rv;
      r = '0;
      for (int j = 0; j < N; j++) begin
         jv = LOGN'(j);
         for (int b = 0; b < LOGN; b++) begin
            rv[b] = jv[LOGN-1-b];
         end
         r[j] = x[rv];
      end
      return r;
`else
      return x;
`endif
   endfunction

   // Next-state and next-output logic; clear wins over every handshake.
   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      if (clear) begin
         state_d = IDLE;
         u_d     = '0;
         cnt_d   = '0;
         stage_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               u_d     = '0;
               cnt_d   = '0;
               stage_d = '0;
               state_d = LOAD;
            end
            LOAD: begin
               if (in_valid) begin
                  u_d = (u_q & ~info_slot(cnt_q)) | (info_slot(cnt_q) & {N{in_bit}});
                  if (cnt_q == CW'(K - 1)) begin
                     cnt_d   = '0;
                     stage_d = '0;
                     state_d = ENCODE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  state_d = LOAD;
               end
            end
            ENCODE: begin
               u_d = butterfly(u_q, stage_q);
               if (stage_q == LOGN'(LOGN - 1)) begin
                  stage_d = '0;
                  state_d = OUT;
               end else begin
                  stage_d = stage_q + LOGN'(1);
               end
            end
            OUT: begin
               if (cw_ready) begin
                  state_d = IDLE;
               end else begin
                  state_d = OUT;
               end
            end
            default: begin
               state_d = IDLE;
               u_d     = '0;
               cnt_d   = '0;
               stage_d = '0;
            end
         endcase
      end
      in_ready_d = (state_d == LOAD);
      cw_valid_d = (state_d == OUT);
      busy_d     = (state_d != IDLE);
      if (state_d == OUT) begin
         cw_data_d = out_order(u_d);
      end else begin
         cw_data_d = '0;
      end
   end

   // State, working register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         u_q        <= '0;
         cnt_q      <= '0;
         stage_q    <= '0;
         in_ready_q <= 1'b0;
         cw_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cw_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         u_q        <= u_d;
         cnt_q      <= cnt_d;
         stage_q    <= stage_d;
         in_ready_q <= in_ready_d;
         cw_valid_q <= cw_valid_d;
         busy_q     <= busy_d;
         cw_data_q  <= cw_data_d;
      end
   end

   assign in_ready = in_ready_q;
   assign cw_valid = cw_valid_q;
   assign busy     = busy_q;
   assign cw_data  = cw_data_q;

endmodule

// File: tb/tb_polar_encoder_seq.sv
// Directed self-checking bench for polar_encoder_seq with default parameters (N=8, K=4).
module tb_polar_encoder_seq;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       cw_valid;
   logic       cw_ready;
   logic [7:0] cw_data;
   logic       busy;

   int total = 0;
   int bad   = 0;

`ifdef POLAR_ENC_BITREV_EN
   localparam logic [7:0] EXP_U3  = 8'h55;
`else
   localparam logic [7:0] EXP_U3  = 8'h0F;
`endif
   localparam logic [7:0] EXP_ALL = 8'h96;
   localparam logic [7:0] EXP_U7  = 8'hFF;

   polar_encoder_seq #(.N(8), .K(4), .FROZEN_MASK(8'b0001_0111)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .in_ready (in_ready),
      .cw_valid (cw_valid),
      .cw_ready (cw_ready),
      .cw_data  (cw_data),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_bit   = b;
      tick();
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   // bits[0] is sent first; expects cw_valid on the third edge after the accepting edge.
   task automatic run_frame(input logic [3:0] bits, input logic [7:0] exp, input string tag,
                            input logic gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            tick();
            tick();
         end
         send_bit(bits[i]);
      end
      for (int c = 0; c < 3; c++) begin
         check({tag, "_lat_novalid"}, {31'd0, cw_valid}, 32'd0);
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         tick();
      end
      check({tag, "_valid"}, {31'd0, cw_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, cw_data}, {24'd0, exp});
      if (cw_ready) begin
         tick();
         check({tag, "_pulse"}, {31'd0, cw_valid}, 32'd0);
         check({tag, "_data_zero"}, {24'd0, cw_data}, 32'd0);
         check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      cw_ready = 1'b1;
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_cw_valid", {31'd0, cw_valid}, 32'd0);
      check("rst_cw_data", {24'd0, cw_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("idle_after_rst", {31'd0, busy}, 32'd0);
      tick();
      check("load_in_ready", {31'd0, in_ready}, 32'd1);
      check("load_busy", {31'd0, busy}, 32'd1);

      run_frame(4'b0001, EXP_U3, "u3", 1'b0);
      run_frame(4'b1111, EXP_ALL, "all1", 1'b0);
      run_frame(4'b1000, EXP_U7, "u7_gaps", 1'b1);

      // Backpressure in OUT with stray in_valid activity.
      cw_ready = 1'b0;
      run_frame(4'b1111, EXP_ALL, "bp", 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_bit   = c[0];
         tick();
         check("bp_hold_valid", {31'd0, cw_valid}, 32'd1);
         check("bp_hold_data", {24'd0, cw_data}, {24'd0, EXP_ALL});
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      cw_ready = 1'b1;
      tick();
      check("bp_release_valid", {31'd0, cw_valid}, 32'd0);
      check("bp_release_idle", {31'd0, busy}, 32'd0);
      run_frame(4'b0001, EXP_U3, "after_bp", 1'b0);

      // clear coincides with the third accepted bit.
      send_bit(1'b1);
      send_bit(1'b0);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      check("clear_idle", {31'd0, busy}, 32'd0);
      check("clear_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("clear_reload", {31'd0, in_ready}, 32'd1);
      run_frame(4'b0001, EXP_U3, "after_clear", 1'b0);

      // Asynchronous reset while ENCODE stage 1 is pending.
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b1);
      end
      tick();
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_cw_valid", {31'd0, cw_valid}, 32'd0);
      check("arst_cw_data", {24'd0, cw_data}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check("arst_reload", {31'd0, in_ready}, 32'd1);
      run_frame(4'b0001, EXP_U3, "after_arst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
